pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the in-order 16-bit core; it replaces the fixed per-stage register blocks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. Carries a control field plus N data channels per stage with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and synchronous flush for branch/hazard squash. Invalid slots present all-zero control so downstream stages see a harmless bubble.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry.sv | 50 +++++
 rtl/pipe_stage_reg.sv | 165 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the reusable pipeline stage register.
// State encoding, statistics counter width and a saturating increment helper.
package pipe_pkg;

  // Occupancy of the stage: no entry, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } pipe_state_t;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Counter increment that sticks at the maximum instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: control field plus NUM_DATA data channels, each held in
// its own register with a shared load enable and asynchronous active-low reset.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 7,
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [CTRL_W-1:0]          d_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0]          q_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] q_data
);

  logic [CTRL_W-1:0] ctrl_reg;

  // Control field: capture on load, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg <= '0;
    end else if (load) begin
      ctrl_reg <= d_ctrl;
    end
  end

  assign q_ctrl = ctrl_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DATA; gi++) begin : g_chan
      logic [DATA_W-1:0] chan_reg;

      // Data channel gi: capture on load, otherwise hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chan_reg <= '0;
        end else if (load) begin
          chan_reg <= d_data[gi*DATA_W +: DATA_W];
        end
      end

      assign q_data[gi*DATA_W +: DATA_W] = chan_reg;
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, a two-entry
// skid buffer (main + skid) for full throughput under backpressure, and a
// synchronous flush. Invalid slots present all-zero control (a bubble).
// Optional macro PIPE_STATS_EN adds saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0]          stall_cnt,
  output logic [STAT_W-1:0]          bubble_cnt
`endif
);

  localparam int PAY_W = NUM_DATA * DATA_W;

  pipe_state_t state_reg;
  pipe_state_t state_next;
  logic        in_ready_reg;
  logic        out_valid_reg;

  logic              main_load;
  logic              skid_load;
  logic              main_from_skid;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [PAY_W-1:0]  main_d_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PAY_W-1:0]  main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PAY_W-1:0]  skid_data;

  // Next-state and entry load decode; flush overrides every transition and
  // suppresses all loads so the input offered that cycle is discarded.
  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_valid) begin
          main_load  = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (in_valid && out_ready) begin
          main_load = 1'b1;
        end else if (in_valid) begin
          skid_load  = 1'b1;
          state_next = SKID;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        // in_ready is low here, so in_valid is ignored.
        if (out_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = FULL;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (flush) begin
      state_next     = EMPTY;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // FSM state with registered handshake outputs derived from the next state,
  // so in_ready/out_valid have no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != SKID);
      out_valid_reg <= (state_next != EMPTY);
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  pipe_entry #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .NUM_DATA(NUM_DATA)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d_ctrl(main_d_ctrl),
    .d_data(main_d_data),
    .q_ctrl(main_ctrl),
    .q_data(main_data)
  );

  pipe_entry #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .NUM_DATA(NUM_DATA)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d_ctrl(in_ctrl),
    .d_data(in_data),
    .q_ctrl(skid_ctrl),
    .q_data(skid_data)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  // Bubbles must never carry live control bits downstream.
  assign out_ctrl  = out_valid_reg ? main_ctrl : '0;
  assign out_data  = main_data;

`ifdef PIPE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_reg;
  logic [STAT_W-1:0] bubble_cnt_reg;

  // Saturating stall/bubble counters; only reset clears them, not flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (out_valid_reg && !out_ready) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
      if (!out_valid_reg) begin
        bubble_cnt_reg <= sat_inc(bubble_cnt_reg);
      end
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A queue of accepted entries serves
// as the reference: the stage behaves as an in-order buffer of depth two.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W   = 16;
  localparam int NUM_DATA = 2;
  localparam int CTRL_W   = 7;
  localparam int DW       = DATA_W * NUM_DATA;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
  } ent_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
`ifdef PIPE_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  ent_t        last_main;
  int unsigned m_stall;
  int unsigned m_bubble;

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .NUM_DATA(NUM_DATA),
    .CTRL_W  (CTRL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, advance the reference model, and
  // return 1 time unit after the edge so outputs can be sampled.
  task automatic cycle(input logic iv, input logic [CTRL_W-1:0] ic,
                       input logic [DW-1:0] id, input logic ordy, input logic fl);
    bit   acc;
    bit   snd;
    ent_t e;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (mq.size() < 2);
    snd = (mq.size() > 0) && ordy;
    if (mq.size() == 0) begin
      if (m_bubble < 32'hFFFF) m_bubble++;
    end else if (!ordy) begin
      if (m_stall < 32'hFFFF) m_stall++;
    end
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (snd) void'(mq.pop_front());
      if (acc) begin
        e.ctrl = ic;
        e.data = id;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) last_main = mq[0];
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    last_main = '0;
    m_stall   = 0;
    m_bubble  = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0;
    model_reset();
    #13;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b ctrl=%h data=%h, required 0/1/0/0",
               out_valid, in_ready, out_ctrl, out_data);
    end
`ifdef PIPE_STATS_EN
    n_checks++;
    if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: stall=%h bubble=%h, required 0/0", stall_cnt, bubble_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: state checked, released");
  endtask

  task automatic test_streaming();
    ent_t exp;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) cycle(1'b1, 7'(i), {16'($urandom), 16'(i)}, 1'b1, 1'b0);
      else        cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (i <= 8) begin
        exp = mq[0];
        if (out_valid !== 1'b1 || out_data[15:0] !== 16'(i) || out_data !== exp.data
            || out_ctrl !== 7'(i) || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_%0d: valid=%b ch0=%h ctrl=%h ready=%b, required 1/%h/%h/1",
                   i, out_valid, out_data[15:0], out_ctrl, in_ready, 16'(i), 7'(i));
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_drain: valid=%b, required 0", out_valid);
      end
      $display("stream cycle %0d: valid=%b ch0=%h", i, out_valid, out_data[15:0]);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 7'h11, {16'h1234, 16'hAAAA}, 1'b0, 1'b0);
    cycle(1'b1, 7'h22, {16'h5678, 16'hBBBB}, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data[15:0] !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL bp_skid: ready=%b valid=%b ch0=%h, required 0/1/aaaa",
               in_ready, out_valid, out_data[15:0]);
    end
    cycle(1'b1, 7'h33, {16'h0, 16'hDDDD}, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_data[15:0] !== 16'hAAAA || out_ctrl !== 7'h11) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b ch0=%h ctrl=%h, required 0/aaaa/11",
               in_ready, out_data[15:0], out_ctrl);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data[15:0] !== 16'hBBBB || out_ctrl !== 7'h22 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b ch0=%h ctrl=%h ready=%b, required 1/bbbb/22/1",
               out_valid, out_data[15:0], out_ctrl, in_ready);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b ready=%b ctrl=%h, required 0/1/0",
               out_valid, in_ready, out_ctrl);
    end
    $display("backpressure: A held under stall, A then B delivered");
  endtask

  task automatic test_flush();
    cycle(1'b1, 7'h44, {16'h0, 16'h1111}, 1'b0, 1'b0);
    cycle(1'b1, 7'h55, {16'h0, 16'h2222}, 1'b0, 1'b0);
    cycle(1'b1, 7'h66, {16'hCCCC, 16'hCCCC}, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_skid: valid=%b ctrl=%h ready=%b, required 0/0/1",
               out_valid, out_ctrl, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out_data[15:0] === 16'hCCCC) begin
        n_fail++;
        $display("FAIL flush_after_%0d: valid=%b ch0=%h, required 0 and not cccc",
                 i, out_valid, out_data[15:0]);
      end
    end
    $display("flush: skid state squashed, cccc discarded");
  endtask

  task automatic test_bubble();
    cycle(1'b0, 7'h7F, {16'h0, 16'h7777}, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 7'h00) begin
      n_fail++;
      $display("FAIL bubble_zero: valid=%b ctrl=%h, required 0/00", out_valid, out_ctrl);
    end
    cycle(1'b1, 7'h7F, {16'h0, 16'h7777}, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 7'h7F) begin
      n_fail++;
      $display("FAIL bubble_live: valid=%b ctrl=%h, required 1/7f", out_valid, out_ctrl);
    end
    cycle(1'b0, 7'h7F, '0, 1'b1, 1'b0);
    $display("bubble: ctrl zero when invalid, 7f when valid");
  endtask

  task automatic test_random();
    ent_t exp;
    logic [CTRL_W-1:0] ec;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 7'($urandom), 32'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      exp = (mq.size() > 0) ? mq[0] : last_main;
      ec  = (mq.size() > 0) ? exp.ctrl : '0;
      n_checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || out_ctrl !== ec
          || (mq.size() > 0 && out_data !== exp.data)) begin
        n_fail++;
        $display("FAIL random_%0d: valid=%b ready=%b ctrl=%h data=%h, required %b/%b/%h/%h",
                 i, out_valid, in_ready, out_ctrl, out_data,
                 mq.size() > 0, mq.size() < 2, ec, exp.data);
      end
`ifdef PIPE_STATS_EN
      n_checks++;
      if (stall_cnt !== 16'(m_stall) || bubble_cnt !== 16'(m_bubble)) begin
        n_fail++;
        $display("FAIL random_cnt_%0d: stall=%0d bubble=%0d, required %0d/%0d",
                 i, stall_cnt, bubble_cnt, m_stall, m_bubble);
      end
`endif
      $display("random %0d: valid=%b ready=%b ctrl=%h data=%h", i, out_valid, in_ready, out_ctrl, out_data);
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b1, 7'h0A, {16'h0, 16'hA0A0}, 1'b0, 1'b0);
    cycle(1'b1, 7'h0B, {16'h0, 16'hB0B0}, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ctrl=%h ready=%b data=%h, required 0/0/1/0",
               out_valid, out_ctrl, in_ready, out_data);
    end
`ifdef PIPE_STATS_EN
    n_checks++;
    if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_cnt: stall=%h bubble=%h, required 0/0", stall_cnt, bubble_cnt);
    end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 7'h0C, {16'h0, 16'hC0C0}, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data[15:0] !== 16'hC0C0 || out_ctrl !== 7'h0C) begin
      n_fail++;
      $display("FAIL reset_first_accept: valid=%b ch0=%h ctrl=%h, required 1/c0c0/0c",
               out_valid, out_data[15:0], out_ctrl);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    $display("reset mid-stream: cleared, first accept after release");
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats_saturate();
    cycle(1'b1, 7'h01, {16'h0, 16'h5A5A}, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_stall)) begin
      n_fail++;
      $display("FAIL stall_saturate: stall=%h, required ffff", stall_cnt);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'(m_bubble)) begin
      n_fail++;
      $display("FAIL stats_after_flush: stall=%h bubble=%0d, required ffff/%0d",
               stall_cnt, bubble_cnt, m_bubble);
    end
    $display("stats: stall=%h bubble=%0d after flush", stall_cnt, bubble_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
    test_reset_midstream();
`ifdef PIPE_STATS_EN
    test_stats_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
